// File: rtl/charlieplex_keyscan_pkg.sv
// Shared definitions for the charlieplexed key scanner and the LED charlieplexer:
// key/LED numbering, derived sizes and the scanner state encoding.
package charlieplex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE,
    ST_EMIT
  } scan_state_e;

  // Switch between column x (pulled high) and row y (driven low); x != y.
  function automatic int idx(input int x, input int y, input int pincount);
    if (x > y) return (pincount - 1) * x + y;
    else       return (pincount - 1) * x + y - 1;
  endfunction

  function automatic int calc_keycount(input int pincount);
    return pincount * (pincount - 1);
  endfunction

  function automatic int calc_indexbits(input int pincount);
    return $clog2(calc_keycount(pincount));
  endfunction

endpackage

// File: rtl/charlieplex_keyscan_if.sv
// Key event channel: valid/ready handshake carrying the changed key and its new state.
interface charlieplex_keyscan_if
  import charlieplex_pkg::*;
#(
  parameter int INDEXBITS = calc_indexbits(4)
);
  logic                 evt_valid;
  logic                 evt_ready;
  logic [INDEXBITS-1:0] evt_index;
  logic                 evt_pressed;

  modport master (output evt_valid, evt_index, evt_pressed, input evt_ready);
  modport slave  (input evt_valid, evt_index, evt_pressed, output evt_ready);
endinterface

// File: rtl/charlieplex_keyscan_debounce.sv
// Per-key debounce: counts consecutive frames whose raw sample disagrees with the
// stable state and flips the stable state once the count reaches DEBOUNCE_FRAMES.
module keyscan_debounce
  import charlieplex_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic update_i,
  input  logic raw_i,
  output logic stable_o,
  output logic flip_o
);
  localparam int CNTBITS = $clog2(DEBOUNCE_FRAMES + 1);

  logic [CNTBITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic               stable_q, stable_d;

  // Counter and stable flop only move in the frame-update cycle.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_o   = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    if (update_i) begin
      if (raw_i == stable_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CNTBITS'(DEBOUNCE_FRAMES)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
        flip_o   = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/charlieplex_keyscan.sv
// Charlieplexed keypad scanner: drives one row low at a time, samples the pulled-up
// columns, debounces every key once per frame and reports changes as events.
module charlieplex_keyscan
  import charlieplex_pkg::*;
#(
  parameter  int PINCOUNT        = 4,
  parameter  int SETTLE_CYCLES   = 16,
  parameter  int DEBOUNCE_FRAMES = 4,
  localparam int KEYCOUNT        = calc_keycount(PINCOUNT),
  localparam int INDEXBITS       = calc_indexbits(PINCOUNT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PINCOUNT-1:0] pin_in,
  output logic [PINCOUNT-1:0] out_en,
  output logic [PINCOUNT-1:0] out_value,
  output logic [KEYCOUNT-1:0] key_state,
  output logic                frame_done,
  charlieplex_keyscan_if.master evt
);
  localparam int ROWBITS = (PINCOUNT > 1) ? $clog2(PINCOUNT) : 1;
  localparam int SETBITS = $clog2(SETTLE_CYCLES);

  scan_state_e         state_q, state_d;
  logic [ROWBITS-1:0]  row_q, row_d;
  logic [SETBITS-1:0]  settle_q, settle_d;
  logic [KEYCOUNT-1:0] raw_q, raw_d;
  logic [KEYCOUNT-1:0] pending_q, pending_d;
  logic [PINCOUNT-1:0] sync1_q, sync2_q;
  logic [KEYCOUNT-1:0] sample_sel, sample_val, flip, lowest;
  logic                update;

  // For each key, which row samples it and what the synchronized column reads.
  for (genvar y = 0; y < PINCOUNT; y++) begin : g_row
    for (genvar x = 0; x < PINCOUNT; x++) begin : g_col
      if (x != y) begin : g_key
        localparam int K = idx(x, y, PINCOUNT);
        assign sample_sel[K] = (row_q == ROWBITS'(y));
        assign sample_val[K] = ~sync2_q[x];
      end
    end
  end

  for (genvar k = 0; k < KEYCOUNT; k++) begin : g_deb
    keyscan_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .update_i (update),
      .raw_i    (raw_q[k]),
      .stable_o (key_state[k]),
      .flip_o   (flip[k])
    );
  end

  assign out_value = '0;

  // Two-flop synchronizer; idles high to match the external pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end

  // Lowest pending key is offered first; its fields hold while unacknowledged.
  always_comb begin
    lowest          = pending_q & (~pending_q + 1'b1);
    evt.evt_pressed = |(key_state & lowest);
    evt.evt_index   = '0;
    for (int k = KEYCOUNT - 1; k >= 0; k--) begin
      if (pending_q[k]) evt.evt_index = INDEXBITS'(k);
    end
  end

  // Scan FSM. An aborted frame leaves raw partly stale, which is harmless because
  // every raw bit is rewritten by its row before the next update cycle.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    settle_d      = settle_q;
    raw_d         = raw_q;
    pending_d     = pending_q;
    out_en        = '0;
    update        = 1'b0;
    frame_done    = 1'b0;
    evt.evt_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        row_d    = '0;
        settle_d = '0;
        if (enable) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        out_en = PINCOUNT'(1) << row_q;
        if (!enable) begin
          state_d  = ST_IDLE;
          row_d    = '0;
          settle_d = '0;
        end else if (settle_q == SETBITS'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        out_en = PINCOUNT'(1) << row_q;
        if (!enable) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          raw_d = (raw_q & ~sample_sel) | (sample_val & sample_sel);
          if (row_q == ROWBITS'(PINCOUNT - 1)) begin
            row_d   = '0;
            state_d = ST_UPDATE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_UPDATE: begin
        update     = 1'b1;
        frame_done = 1'b1;
        pending_d  = pending_q | flip;
        if (|pending_d) state_d = ST_EMIT;
        else if (enable) state_d = ST_SETTLE;
        else state_d = ST_IDLE;
      end
      ST_EMIT: begin
        evt.evt_valid = 1'b1;
        if (evt.evt_ready) begin
          pending_d = pending_q & ~lowest;
          if (pending_d == '0) state_d = enable ? ST_SETTLE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      settle_q  <= '0;
      raw_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      settle_q  <= settle_d;
      raw_q     <= raw_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_charlieplex_keyscan.sv
// Bench for charlieplex_keyscan (4 pins, settle 4, debounce 2): a pad model turns the
// pressed-key vector into pin readback, and a scoreboard checks every accepted event.
module tb_charlieplex_keyscan;
  import charlieplex_pkg::*;

  typedef struct packed {
    logic [3:0] index;
    logic       pressed;
  } evt_t;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic [3:0]  pinIn;
  logic [3:0]  outEn;
  logic [3:0]  outValue;
  logic [11:0] keyState;
  logic        frameDone;
  logic [11:0] keys;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  evt_t sb[$];

  charlieplex_keyscan_if #(.INDEXBITS(4)) evtBus ();

  charlieplex_keyscan #(
    .PINCOUNT        (4),
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .enable     (enable),
    .pin_in     (pinIn),
    .out_en     (outEn),
    .out_value  (outValue),
    .key_state  (keyState),
    .frame_done (frameDone),
    .evt        (evtBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand numbering of the key matrix: column x pulled high, row y driven low.
  function automatic logic [3:0] keyIdx(input int x, input int y);
    return 4'((x > y) ? 3 * x + y : 3 * x + y - 1);
  endfunction

  // Pad model: a driven row reads low, and a pressed key pulls its column low.
  always_comb begin
    pinIn = '1;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        if (outEn[y]) begin
          if (x == y) pinIn[x] = 1'b0;
          else if (keys[keyIdx(x, y)]) pinIn[x] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted event must match the next expected one.
  always @(negedge clk) begin
    if (rstN && evtBus.evt_valid && evtBus.evt_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL evtUnexpected: got index %0d pressed %0b, required no event",
                 evtBus.evt_index, evtBus.evt_pressed);
      end else begin
        evt_t exp;
        exp = sb.pop_front();
        if (evtBus.evt_index !== exp.index || evtBus.evt_pressed !== exp.pressed) begin
          errors++;
          $display("[TB] FAIL evtMatch: got index %0d pressed %0b, required index %0d pressed %0b",
                   evtBus.evt_index, evtBus.evt_pressed, exp.index, exp.pressed);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Inputs change just after a rising edge so they are settled at the sampling edge.
  task automatic applyStimulus(input logic enV, input logic rdyV, input logic [11:0] keyV);
    @(posedge clk);
    #1;
    enable           = enV;
    evtBus.evt_ready = rdyV;
    keys             = keyV;
  endtask

  task automatic waitFrameDone(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frameDone && cycles < 200);
    if (!frameDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL frameDoneTimeout: got no frame_done, required one within 200 cycles");
    end
  endtask

  initial begin
    rstN             = 1'b0;
    enable           = 1'b0;
    evtBus.evt_ready = 1'b1;
    keys             = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstOutEn", 32'(outEn), 32'h0);
    checkOutput("rstOutValue", 32'(outValue), 32'h0);
    checkOutput("rstEvtValid", 32'(evtBus.evt_valid), 32'h0);
    checkOutput("rstFrameDone", 32'(frameDone), 32'h0);
    checkOutput("rstKeyState", 32'(keyState), 32'h0);
    rstN = 1'b1;

    // Idle scanning: row walk, frame length, no events
    applyStimulus(1'b1, 1'b1, 12'h000);
    waitFrameDone(cyc);
    for (int c = 0; c < 21; c++) begin
      logic [4:0] expv;
      @(negedge clk);
      expv = (c == 20) ? 5'b10000 : {1'b0, 4'(4'b0001 << (c / 5))};
      checkOutput($sformatf("rowWalk%0d", c), 32'({frameDone, outEn}), 32'(expv));
    end
    waitFrameDone(cyc);
    checkOutput("framePeriod", 32'(cyc), 32'd21);

    // Key 6 held for two frames, then released
    sb.push_back('{index: 4'd6, pressed: 1'b1});
    applyStimulus(1'b1, 1'b1, 12'h040);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    @(negedge clk);
    checkOutput("key6PressValid", 32'(evtBus.evt_valid), 32'h1);
    checkOutput("key6PressState", 32'(keyState), 32'h040);
    sb.push_back('{index: 4'd6, pressed: 1'b0});
    applyStimulus(1'b1, 1'b1, 12'h000);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    @(negedge clk);
    checkOutput("key6RelValid", 32'(evtBus.evt_valid), 32'h1);
    checkOutput("key6RelState", 32'(keyState), 32'h000);

    // Key 6 pressed for a single frame is filtered out
    applyStimulus(1'b1, 1'b1, 12'h040);
    waitFrameDone(cyc);
    applyStimulus(1'b1, 1'b1, 12'h000);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    checkOutput("glitchState", 32'(keyState), 32'h000);
    @(negedge clk);
    checkOutput("glitchNoEvt", 32'(evtBus.evt_valid), 32'h0);

    // Keys 0 and 11 together with the consumer stalled
    sb.push_back('{index: 4'd0, pressed: 1'b1});
    sb.push_back('{index: 4'd11, pressed: 1'b1});
    applyStimulus(1'b1, 1'b0, 12'h801);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d", i),
                  32'({evtBus.evt_valid, evtBus.evt_index, evtBus.evt_pressed, outEn}),
                  32'({1'b1, 4'd0, 1'b1, 4'b0000}));
    end
    applyStimulus(1'b1, 1'b1, 12'h801);
    repeat (2) @(negedge clk);
    checkOutput("dualState", 32'(keyState), 32'h801);
    sb.push_back('{index: 4'd0, pressed: 1'b0});
    sb.push_back('{index: 4'd11, pressed: 1'b0});
    applyStimulus(1'b1, 1'b1, 12'h000);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    repeat (3) @(negedge clk);
    checkOutput("dualRelState", 32'(keyState), 32'h000);

    // Enable dropped in the row-2 sample cycle, after key 6 counted one frame
    waitFrameDone(cyc);
    applyStimulus(1'b1, 1'b1, 12'h040);
    waitFrameDone(cyc);
    repeat (14) @(posedge clk);
    applyStimulus(1'b0, 1'b1, 12'h040);
    @(negedge clk);
    checkOutput("abortSampleRow2", 32'(outEn), 32'h4);
    @(negedge clk);
    checkOutput("abortOutEn", 32'(outEn), 32'h0);
    checkOutput("abortIdle", 32'(dut.state_q), 32'(ST_IDLE));
    repeat (4) @(negedge clk);
    checkOutput("abortHold", 32'({frameDone, outEn}), 32'h0);
    checkOutput("abortKeyState", 32'(keyState), 32'h000);
    sb.push_back('{index: 4'd6, pressed: 1'b1});
    applyStimulus(1'b1, 1'b1, 12'h040);
    @(negedge clk);
    checkOutput("reenIdle", 32'(outEn), 32'h0);
    @(negedge clk);
    checkOutput("reenRow0", 32'(outEn), 32'h1);
    waitFrameDone(cyc);
    checkOutput("reenFrameLen", 32'(cyc), 32'd20);
    @(negedge clk);
    checkOutput("reenKeyState", 32'(keyState), 32'h040);

    // Asynchronous reset while an event is stalled
    applyStimulus(1'b1, 1'b0, 12'h000);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    @(negedge clk);
    checkOutput("preRstEvt", 32'({evtBus.evt_valid, evtBus.evt_index, evtBus.evt_pressed}),
                32'({1'b1, 4'd6, 1'b0}));
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(evtBus.evt_valid), 32'h0);
    checkOutput("asyncRstOutEn", 32'(outEn), 32'h0);
    checkOutput("asyncRstKeys", 32'(keyState), 32'h000);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b1, 12'h000);
    waitFrameDone(cyc);
    waitFrameDone(cyc);
    @(negedge clk);
    checkOutput("postRstKeys", 32'(keyState), 32'h000);
    checkOutput("postRstNoEvt", 32'(evtBus.evt_valid), 32'h0);
    checkOutput("sbDrained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
